// File: rtl/cosine_phase_sweep_pkg.sv
// Shared types and default constants for the cosine phase sweep and its later DDS siblings.
package cosine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int FRAME_MAX_DEF = 480;
    localparam int N_DIV_DEF     = 8;
    localparam int BASE_STEP_DEF = 11339;

endpackage

// File: rtl/cosine_phase_sweep_if.sv
// Result handshake from the phase sweep to the NCO/cosine LUT stage.
interface cosine_phase_sweep_if #(
    parameter int PHASE_W = 32
) ();

    logic [PHASE_W-1:0] phase_inc;
    logic               phase_valid;
    logic               phase_ready;

    modport master (output phase_inc, output phase_valid, input  phase_ready);
    modport slave  (input  phase_inc, input  phase_valid, output phase_ready);

endinterface

// File: rtl/cosine_phase_sweep_seq_div.sv
// Restoring divider producing one quotient bit per cycle, MSB first, W cycles after start.
module seq_div #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quotient_o,
    output logic         done_o
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    logic [W-1:0]     rem_q;
    logic [W-1:0]     quo_q;
    logic [W-1:0]     dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic [W:0]       partial;
    logic [W:0]       diff;
    logic             fits;

    always_comb begin
        partial = {rem_q, quo_q[W-1]};
        diff    = partial - {1'b0, dvs_q};
        fits    = (partial >= {1'b0, dvs_q});
    end

    // The quotient register doubles as the dividend shifter: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= fits ? diff[W-1:0] : partial[W-1:0];
            quo_q <= {quo_q[W-2:0], fits};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o     = run_q && (cnt_q == LAST);
    assign quotient_o = quo_q;

endmodule

// File: rtl/cosine_phase_sweep.sv
// Frame-stepped DDS phase increment: BASE_STEP*(FRAME_MAX + n*K) / (K*N_DIV), handed out over valid/ready.
module cosine_phase_sweep
    import cosine_pkg::*;
#(
    parameter int PHASE_W   = 32,
    parameter int FRAME_MAX = FRAME_MAX_DEF,
    parameter int N_DIV     = N_DIV_DEF,
    parameter int BASE_STEP = BASE_STEP_DEF,
    parameter int IDX_W     = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vga_vs,
    input  logic                 sweep_clr,
    input  logic                 sweep_en,
    input  logic                 load_en,
    input  logic [IDX_W-1:0]     load_idx,
    cosine_phase_sweep_if.master phase_if,
    output logic [IDX_W-1:0]     frame_idx,
    output logic                 busy
);

    localparam int               SHIFT   = $clog2(N_DIV);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FRAME_MAX);

    state_e             state_q;
    logic               vs_q;
    logic               pending_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               idx_wr;
    logic               frame_evt;
    logic [PHASE_W-1:0] inc_q;
    logic               valid_q;
    logic [PHASE_W-1:0] mul_k;
    logic [PHASE_W-1:0] mul_n;
    logic [PHASE_W-1:0] divisor;
    logic [PHASE_W-1:0] dividend;
    logic [PHASE_W-1:0] quotient;
    logic               div_done;

    always_comb begin
        frame_evt = vs_q && !vga_vs;
        idx_d     = idx_q;
        idx_wr    = 1'b0;
        if (sweep_clr) begin
            idx_d  = '0;
            idx_wr = 1'b1;
        end else if (load_en) begin
            idx_d  = (load_idx > IDX_MAX) ? IDX_MAX : load_idx;
            idx_wr = 1'b1;
        end else if (frame_evt && sweep_en) begin
            idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            idx_wr = 1'b1;
        end
    end

    // N_DIV is a power of two, so K, n and the divisor are plain shifts and masks of the index.
    always_comb begin
        mul_k    = PHASE_W'(idx_q >> SHIFT) + PHASE_W'(1);
        mul_n    = PHASE_W'(idx_q[SHIFT-1:0]);
        divisor  = mul_k << SHIFT;
        dividend = PHASE_W'(BASE_STEP) * (PHASE_W'(FRAME_MAX) + mul_n * mul_k);
    end

    seq_div #(.W(PHASE_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (state_q == MUL),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .quotient_o (quotient),
        .done_o     (div_done)
    );

    // A write landing while IDLE consumes pending re-arms it, so the latest index always gets computed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vs_q      <= 1'b1;
            pending_q <= 1'b0;
            idx_q     <= '0;
            inc_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            vs_q  <= vga_vs;
            idx_q <= idx_d;
            if (valid_q && phase_if.phase_ready) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        pending_q <= 1'b0;
                        state_q   <= MUL;
                    end
                end
                MUL: state_q <= DIV;
                DIV: begin
                    if (div_done) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!valid_q || phase_if.phase_ready) begin
                        inc_q   <= quotient;
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (idx_wr) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign phase_if.phase_inc   = inc_q;
    assign phase_if.phase_valid = valid_q;
    assign frame_idx            = idx_q;
    assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_cosine_phase_sweep.sv
// Bench for cosine_phase_sweep: directed plan items plus random traffic against a cycle-level reference model.
module tb_cosine_phase_sweep;

    localparam int PHASE_W   = 32;
    localparam int FRAME_MAX = 480;
    localparam int N_DIV     = 8;
    localparam int BASE_STEP = 11339;
    localparam int IDX_W     = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             vgaVs;
    logic             sweepClr;
    logic             sweepEn;
    logic             loadEn;
    logic [IDX_W-1:0] loadIdx;
    logic             phaseReady;
    logic [IDX_W-1:0] frameIdx;
    logic             busy;

    int checkCount = 0;
    int errorCount = 0;

    cosine_phase_sweep_if #(.PHASE_W(PHASE_W)) phaseIf ();
    assign phaseIf.phase_ready = phaseReady;

    cosine_phase_sweep #(
        .PHASE_W   (PHASE_W),
        .FRAME_MAX (FRAME_MAX),
        .N_DIV     (N_DIV),
        .BASE_STEP (BASE_STEP),
        .IDX_W     (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vga_vs    (vgaVs),
        .sweep_clr (sweepClr),
        .sweep_en  (sweepEn),
        .load_en   (loadEn),
        .load_idx  (loadIdx),
        .phase_if  (phaseIf),
        .frame_idx (frameIdx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Direct evaluation of the increment formula for one frame index.
    function automatic longint unsigned expectedInc(input int idx);
        longint unsigned k;
        longint unsigned n;
        longint unsigned dividend;
        k        = longint'(idx / N_DIV) + 1;
        n        = longint'(idx % N_DIV);
        dividend = (longint'(BASE_STEP) * (longint'(FRAME_MAX) + n * k)) & ((64'd1 << PHASE_W) - 1);
        return dividend / (k * N_DIV);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit clr, input bit en, input bit ld, input int idx,
                                 input bit vs, input bit rdy);
        @(negedge clk);
        sweepClr   = clr;
        sweepEn    = en;
        loadEn     = ld;
        loadIdx    = IDX_W'(idx);
        vgaVs      = vs;
        phaseReady = rdy;
    endtask

    // Reference model: index, pending request, a cycle counter for the computation
    // (0 idle, 1 operand capture, 2..W+1 division, W+2 waiting for the output) and the output slot.
    bit              modelArmed = 1'b0;
    int              mIdx;
    bit              mPending;
    int              mPhase;
    longint unsigned mQuot;
    bit              mValid;
    longint unsigned mInc;
    bit              mVsPrev;

    always @(posedge clk) begin : modelStep
        bit              ev;
        bit              wr;
        int              nIdx;
        int              nPhase;
        bit              nPending;
        bit              nValid;
        longint unsigned nInc;
        if (rst) begin
            mIdx       = 0;
            mPending   = 1'b0;
            mPhase     = 0;
            mQuot      = 0;
            mValid     = 1'b0;
            mInc       = 0;
            mVsPrev    = 1'b1;
            modelArmed = 1'b1;
        end else if (modelArmed) begin
            ev   = mVsPrev && !vgaVs;
            nIdx = mIdx;
            wr   = 1'b0;
            if (sweepClr) begin
                nIdx = 0;
                wr   = 1'b1;
            end else if (loadEn) begin
                nIdx = (int'(loadIdx) > FRAME_MAX) ? FRAME_MAX : int'(loadIdx);
                wr   = 1'b1;
            end else if (ev && sweepEn) begin
                nIdx = (mIdx == FRAME_MAX) ? 0 : mIdx + 1;
                wr   = 1'b1;
            end
            nPhase   = mPhase;
            nPending = mPending;
            nValid   = (mValid && phaseReady) ? 1'b0 : mValid;
            nInc     = mInc;
            if (mPhase == 0) begin
                if (mPending) begin
                    nPhase   = 1;
                    nPending = 1'b0;
                end
            end else if (mPhase == 1) begin
                mQuot  = expectedInc(mIdx);
                nPhase = 2;
            end else if (mPhase == PHASE_W + 2) begin
                if (!mValid || phaseReady) begin
                    nInc   = mQuot;
                    nValid = 1'b1;
                    nPhase = 0;
                end
            end else begin
                nPhase = mPhase + 1;
            end
            if (wr) nPending = 1'b1;
            mIdx     = nIdx;
            mPhase   = nPhase;
            mPending = nPending;
            mValid   = nValid;
            mInc     = nInc;
            mVsPrev  = vgaVs;
        end
    end

    always @(negedge clk) begin
        if (modelArmed && !rst) begin
            checkOutput("model_frame_idx", 64'(frameIdx), 64'(mIdx));
            checkOutput("model_busy", 64'(busy), (mPhase != 0) ? 64'd1 : 64'd0);
            checkOutput("model_phase_valid", 64'(phaseIf.phase_valid), 64'(mValid));
            checkOutput("model_phase_inc", 64'(phaseIf.phase_inc), mInc);
        end
    end

    task automatic waitValid(input string name);
        int n = 0;
        while (phaseIf.phase_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 64'(phaseIf.phase_valid), 64'd1);
    endtask

    task automatic loadAndWait(input int idx, input int expIdx, input longint unsigned expInc);
        int  cycles = 0;
        applyStimulus(0, 0, 1, idx, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("load_frame_idx", 64'(frameIdx), 64'(expIdx));
        while (phaseIf.phase_valid !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            cycles++;
            #1;
        end
        checkOutput("load_latency", 64'(cycles), 64'(PHASE_W + 3));
        checkOutput("load_phase_inc", 64'(phaseIf.phase_inc), 64'(expInc));
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("load_consumed", 64'(phaseIf.phase_valid), 64'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int              startIdx;
        int              results;
        longint unsigned lastInc;

        rst        = 1'b1;
        vgaVs      = 1'b1;
        sweepClr   = 1'b0;
        sweepEn    = 1'b0;
        loadEn     = 1'b0;
        loadIdx    = '0;
        phaseReady = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("reset_frame_idx", 64'(frameIdx), 64'd0);
        checkOutput("reset_phase_inc", 64'(phaseIf.phase_inc), 64'd0);
        checkOutput("reset_phase_valid", 64'(phaseIf.phase_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);

        checkOutput("pin_model_idx0", expectedInc(0), 64'd680340);
        checkOutput("pin_model_idx9", expectedInc(9), 64'd341587);
        checkOutput("pin_model_idx479", expectedInc(479), 64'd21260);
        checkOutput("pin_model_idx480", expectedInc(480), 64'd11153);

        loadAndWait(0, 0, 680340);
        loadAndWait(9, 9, 341587);
        loadAndWait(479, 479, 21260);
        loadAndWait(480, 480, 11153);
        loadAndWait(500, 480, 11153);

        // Full sweep with wrap, consumer always ready.
        applyStimulus(1, 1, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 1, 1);
        checkOutput("sweep_clear", 64'(frameIdx), 64'd0);
        for (int i = 0; i < 482; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 1);
            applyStimulus(0, 1, 0, 0, 1, 1);
            checkOutput("sweep_idx", 64'(frameIdx), 64'((i + 1) % (FRAME_MAX + 1)));
        end
        repeat (60) @(negedge clk);

        // Disabled frame events.
        startIdx = int'(frameIdx);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            applyStimulus(0, 0, 0, 0, 1, 1);
            checkOutput("disabled_idx", 64'(frameIdx), 64'(startIdx));
            checkOutput("disabled_busy", 64'(busy), 64'd0);
        end

        // Three events inside one computation collapse into two results.
        results = 0;
        lastInc = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 1);
            if (phaseIf.phase_valid === 1'b1) begin results++; lastInc = phaseIf.phase_inc; end
            applyStimulus(0, 1, 0, 0, 1, 1);
            if (phaseIf.phase_valid === 1'b1) begin results++; lastInc = phaseIf.phase_inc; end
        end
        applyStimulus(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 150; i++) begin
            if (phaseIf.phase_valid === 1'b1) begin results++; lastInc = phaseIf.phase_inc; end
            @(negedge clk);
        end
        checkOutput("coalesce_count", 64'(results), 64'd2);
        checkOutput("coalesce_last", lastInc, expectedInc(startIdx + 3));

        // Stall in DONE while the first result is held.
        applyStimulus(0, 0, 1, 9, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        waitValid("stall_first_valid");
        applyStimulus(0, 0, 1, 479, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        repeat (50) @(negedge clk);
        checkOutput("stall_busy", 64'(busy), 64'd1);
        checkOutput("stall_valid", 64'(phaseIf.phase_valid), 64'd1);
        checkOutput("stall_inc_held", 64'(phaseIf.phase_inc), 64'd341587);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("stall_second_valid", 64'(phaseIf.phase_valid), 64'd1);
        checkOutput("stall_second_inc", 64'(phaseIf.phase_inc), 64'd21260);
        checkOutput("stall_released", 64'(busy), 64'd0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("stall_drained", 64'(phaseIf.phase_valid), 64'd0);

        // Reset in the middle of a division.
        applyStimulus(0, 0, 1, 480, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        repeat (10) @(negedge clk);
        checkOutput("midrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_frame_idx", 64'(frameIdx), 64'd0);
        checkOutput("midrst_phase_inc", 64'(phaseIf.phase_inc), 64'd0);
        checkOutput("midrst_phase_valid", 64'(phaseIf.phase_valid), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        repeat (60) @(negedge clk);
        checkOutput("midrst_no_result", 64'(phaseIf.phase_valid), 64'd0);
        checkOutput("midrst_idle", 64'(busy), 64'd0);

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 799) == 0);
            sweepClr   = ($urandom_range(0, 63) == 0);
            loadEn     = ($urandom_range(0, 47) == 0);
            loadIdx    = IDX_W'($urandom_range(0, 511));
            sweepEn    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) vgaVs = ~vgaVs;
            phaseReady = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        rst      = 1'b0;
        sweepClr = 1'b0;
        loadEn   = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cosine_phase_sweep.md
# cosine_phase_sweep

Parametrised, clocked successor to the frame-driven cosine phase-increment generator. On each enabled VGA frame boundary it steps a frame index, splits it into a harmonic index K and a sub-step n, and computes the DDS phase increment BASE_STEP·(FRAME_MAX + n·K) / (K·N_DIV) with a multi-cycle restoring divider. Results go to the NCO/cosine LUT stage over a valid/ready handshake. It sits between the VGA timing generator and the DDS accumulator.

## Interface
- PHASE_W, 32, width of phase increment, dividend and divider datapath
- FRAME_MAX, 480, last frame index; the count runs 0..FRAME_MAX inclusive
- N_DIV, 8, sub-steps per harmonic; power of two ≥ 2
- BASE_STEP, 11339, base phase step constant
- IDX_W, 9, frame index width; must hold FRAME_MAX
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- vga_vs  in  1  VGA vertical sync, synchronous to clk; the falling edge is the frame event
- sweep_clr  in  1  synchronous clear of the frame index to 0
- sweep_en  in  1  when 1, a frame event advances the index
- load_en  in  1  manual mode: on the next cycle, load load_idx and start a computation
- load_idx  in  IDX_W  manual frame index; values > FRAME_MAX clamp to FRAME_MAX
- phase_inc  out  PHASE_W  computed phase increment
- phase_valid  out  1  phase_inc holds a new, unconsumed result
- phase_ready  in  1  consumer accepts the result when phase_valid && phase_ready
- frame_idx  out  IDX_W  current frame index
- busy  out  1  computation in progress

## Operation
- Reset: frame_idx=0, phase_inc=0, phase_valid=0, busy=0, FSM=IDLE, pending=0, vs_q=1.
- Frame event: vs_q && !vga_vs, where vs_q is vga_vs registered.
- Index update, evaluated in priority order:
  - sweep_clr: idx←0.
  - else load_en: idx←min(load_idx, FRAME_MAX).
  - else event && sweep_en: idx←(idx==FRAME_MAX) ? 0 : idx+1.
  - else hold.
- Every index write sets pending. This includes a clear, and includes a write of an unchanged value.
- K = idx/N_DIV + 1 (shift). n = idx mod N_DIV (mask). Divisor = K·N_DIV (shift).
- Dividend = BASE_STEP·(FRAME_MAX + n·K), truncated to PHASE_W bits.
- Result = floor(dividend/divisor).
- FSM:
  - IDLE: if pending, clear pending and go to MUL. Otherwise stay.
  - MUL (1 cycle): register the dividend and divisor. Go to DIV.
  - DIV (PHASE_W cycles): restoring division, one quotient bit per cycle, MSB first. After the last bit, go to DONE.
  - DONE: if !phase_valid, or phase_valid && phase_ready in this cycle, write phase_inc, set phase_valid and go to IDLE. Otherwise stall in DONE.
- phase_valid clears on handshake unless a new result is written in the same cycle.
- busy = (state != IDLE).
- Events while busy: the index still updates and pending is set. Exactly one recompute follows, using the latest index; intermediate indices are dropped.
- Reset mid-operation: the computation is abandoned and all reset values apply the next cycle.

## Timing
- Frame event: vga_vs falls at cycle t, so vs_q && !vga_vs in t. The index is written at the t edge and visible at t+1.
- FSM leaves IDLE at t+1 and enters MUL. DIV covers t+2 .. t+1+PHASE_W. DONE is at t+2+PHASE_W.
- phase_valid rises at t+3+PHASE_W (35 cycles for PHASE_W=32) if the output is free.
- Back-to-back results: PHASE_W+3 cycles minimum.
- phase_inc is stable while phase_valid && !phase_ready.

## Structure
- cosine_pkg holds the FSM state enum (IDLE, MUL, DIV, DONE) and the default constants (FRAME_MAX, N_DIV, BASE_STEP).
- One sub-module, seq_div (PHASE_W restoring divider, start/done interface), reused by later DDS blocks.
- Index logic, edge detect, multiplier and handshake stay in the top module.

## Test plan
- Reset, then pulse load_en with load_idx=0 -> phase_valid at +35 cycles, phase_inc=680340 (K=1, n=0).
- load_idx=9 -> phase_inc=341587 (K=2, n=1, 5465398/16). load_idx=479 -> 21260 (K=60, n=7). load_idx=480 -> 11153. load_idx=500 -> clamped, frame_idx=480, 11153.
- sweep_en=1 with 482 vga_vs falling edges -> frame_idx goes 0..480 then 0, then 1. Edges with sweep_en=0 leave the index unchanged and start no computation.
- Three frame events inside one computation, phase_ready=1 -> exactly two results. The second uses the final index.
- phase_ready=0 holding one result while a second computation completes -> FSM stalls in DONE and phase_inc is unchanged. Raising phase_ready -> the first result is accepted and the second result appears in the same cycle.
- Assert rst during DIV -> next cycle all outputs are at reset values, and no result appears afterwards without a new event.
